// File: rtl/tick_gen_multi.sv
// Prescaled multi-channel tick generator; optional fast-rate mode under `define FAST_FWD_EN.
// Latency: base_tick 1 cycle after prescaler wrap, tick_out 1 cycle after base_tick; div_ack/div_err 1 cycle after div_wr.
// Backpressure: none; a divisor write is accepted every cycle, en=0 freezes counting.
module tick_gen_multi #(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 2,
   parameter int PRE_W   = 10,
   parameter int PRE_DIV = 1000,
   parameter int CNT_W   = 10,
   parameter int DEF_DIV = 50
) (
   input  logic              origin_clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              div_wr,
   input  logic [CH_W-1:0]   div_sel,
   input  logic [CNT_W-1:0]  div_data,
   input  logic [NUM_CH-1:0] fast,
   output logic              div_ack,
   output logic              div_err,
   output logic              base_tick,
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] clk_out
);

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);
   localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

   logic [PRE_W-1:0]             pre_q, pre_d;
   logic                         base_tick_q, base_tick_d;
   logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt_q, ch_cnt_d;
   logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
   logic [NUM_CH-1:0][CNT_W-1:0] thr;
   logic [NUM_CH-1:0]            tick_q, tick_d;
   logic [NUM_CH-1:0]            clk_q, clk_d;
   logic                         ack_q, ack_d;
   logic                         err_q, err_d;
   logic                         wr_ok;

   // Effective threshold per channel; fast mode runs at a quarter of the divisor, never below 1.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         thr[i] = div_q[i];
`ifdef FAST_FWD_EN
         if (fast[i]) begin
            thr[i] = ((div_q[i] >> 2) == '0) ? CNT_W'(1) : (div_q[i] >> 2);
         end
`endif
      end
   end

`ifndef FAST_FWD_EN
   logic unused_fast;
   assign unused_fast = ^fast;
`endif

   assign wr_ok = div_wr && (32'(div_sel) < NUM_CH) && (div_data != '0);

   always_comb begin
      pre_d       = pre_q;
      base_tick_d = 1'b0;
      ch_cnt_d    = ch_cnt_q;
      div_d       = div_q;
      tick_d      = '0;
      clk_d       = clk_q;
      ack_d       = wr_ok;
      err_d       = div_wr && !wr_ok;

      if (clr) begin
         pre_d    = '0;
         ch_cnt_d = '0;
         clk_d    = '0;
      end else if (en) begin
         if (pre_q == PRE_MAX) begin
            pre_d       = '0;
            base_tick_d = 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
         // >= so a threshold lowered mid-count wraps at the next base tick.
         if (base_tick_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (ch_cnt_q[i] >= thr[i] - 1'b1) begin
                  ch_cnt_d[i] = '0;
                  tick_d[i]   = 1'b1;
                  clk_d[i]    = ~clk_q[i];
               end else begin
                  ch_cnt_d[i] = ch_cnt_q[i] + 1'b1;
               end
            end
         end
      end

      // A write restarts its channel's phase and suppresses that channel's tick on the same edge.
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_ok && (div_sel == CH_W'(i))) begin
            div_d[i]    = div_data;
            ch_cnt_d[i] = '0;
            tick_d[i]   = 1'b0;
            if (!clr) begin
               clk_d[i] = clk_q[i];
            end
         end
      end
   end

   always_ff @(posedge origin_clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q       <= '0;
         base_tick_q <= 1'b0;
         ch_cnt_q    <= '0;
         div_q       <= {NUM_CH{DEF_VAL}};
         tick_q      <= '0;
         clk_q       <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         base_tick_q <= base_tick_d;
         ch_cnt_q    <= ch_cnt_d;
         div_q       <= div_d;
         tick_q      <= tick_d;
         clk_q       <= clk_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
      end
   end

   assign base_tick = base_tick_q;
   assign tick_out  = tick_q;
   assign clk_out   = clk_q;
   assign div_ack   = ack_q;
   assign div_err   = err_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: a base-tick/period model predicts every cycle's outputs.
module tb_tick_gen_multi;

   localparam int NUM_CH  = 3;
   localparam int CH_W    = 2;
   localparam int PRE_W   = 4;
   localparam int PRE_DIV = 4;
   localparam int CNT_W   = 5;
   localparam int DEF_DIV = 3;

   logic              origin_clk = 1'b0;
   logic              rst_n      = 1'b0;
   logic              en         = 1'b0;
   logic              clr        = 1'b0;
   logic              div_wr     = 1'b0;
   logic [CH_W-1:0]   div_sel    = '0;
   logic [CNT_W-1:0]  div_data   = '0;
   logic [NUM_CH-1:0] fast       = '0;
   logic              div_ack, div_err, base_tick;
   logic [NUM_CH-1:0] tick_out, clk_out;

   tick_gen_multi #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .PRE_W(PRE_W), .PRE_DIV(PRE_DIV),
      .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)
   ) dut (
      .origin_clk(origin_clk), .rst_n(rst_n), .en(en), .clr(clr),
      .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data), .fast(fast),
      .div_ack(div_ack), .div_err(div_err), .base_tick(base_tick),
      .tick_out(tick_out), .clk_out(clk_out)
   );

   always #5 origin_clk = ~origin_clk;

   typedef struct packed {
      logic              base;
      logic [NUM_CH-1:0] tick;
      logic [NUM_CH-1:0] clk;
      logic              ack;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   int   t0_hits[$];

   // Reference: base ticks arrive every PRE_DIV enabled cycles; a channel fires once it has seen thr of them.
   int m_pre;
   bit m_base;
   int m_seen [NUM_CH];
   int m_div  [NUM_CH];
   bit m_clk  [NUM_CH];

   function automatic int thr_of(int i, logic [NUM_CH-1:0] f);
      bit use_fast;
      use_fast = f[i];
`ifndef FAST_FWD_EN
      use_fast = 1'b0;
`endif
      if (use_fast) return (m_div[i] / 4 > 0) ? m_div[i] / 4 : 1;
      return m_div[i];
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, want);
      end
   endtask

   task automatic drive(input bit e, input bit c, input bit w, input int sel,
                        input int data, input logic [NUM_CH-1:0] f);
      exp_t x;
      bit   ok;
      bit   fire;
      en = e; clr = c; div_wr = w;
      div_sel = CH_W'(sel); div_data = CNT_W'(data); fast = f;
      ok = w && (sel < NUM_CH) && (data != 0);
      x = '0;
      x.ack = ok;
      x.err = w && !ok;
      if (c) begin
         m_pre = 0;
         for (int i = 0; i < NUM_CH; i++) begin m_seen[i] = 0; m_clk[i] = 1'b0; end
      end else if (e) begin
         fire = m_base;
         if (m_pre == PRE_DIV - 1) begin m_pre = 0; x.base = 1'b1; end
         else m_pre++;
         if (fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
               m_seen[i]++;
               if (m_seen[i] >= thr_of(i, f)) begin
                  m_seen[i] = 0; x.tick[i] = 1'b1; m_clk[i] = !m_clk[i];
               end
            end
         end
      end
      if (ok) begin
         if (x.tick[sel]) begin x.tick[sel] = 1'b0; m_clk[sel] = !m_clk[sel]; end
         m_div[sel]  = data;
         m_seen[sel] = 0;
      end
      m_base = x.base;
      for (int i = 0; i < NUM_CH; i++) x.clk[i] = m_clk[i];
      exp_q.push_back(x);
      @(negedge origin_clk);
   endtask

   task automatic idle(input int n, input logic [NUM_CH-1:0] f);
      repeat (n) drive(1'b1, 1'b0, 1'b0, 0, 0, f);
   endtask

   // Monitor: one expected entry per clock edge once the stimulus is running.
   initial begin
      forever begin
         exp_t e, a;
         @(posedge origin_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            edge_n++;
            a = {base_tick, tick_out, clk_out, div_ack, div_err};
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL edge %0d outputs: got base=%b tick=%b clk=%b ack=%b err=%b, expected base=%b tick=%b clk=%b ack=%b err=%b",
                        edge_n, a.base, a.tick, a.clk, a.ack, a.err, e.base, e.tick, e.clk, e.ack, e.err);
            end
            if (tick_out[0]) t0_hits.push_back(edge_n);
         end
      end
   end

   initial begin
      logic [NUM_CH-1:0] f_r;
      m_pre = 0; m_base = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin m_seen[i] = 0; m_div[i] = DEF_DIV; m_clk[i] = 1'b0; end
      en = 1'b1;
      repeat (3) @(negedge origin_clk);
      chk("reset base_tick", int'(base_tick), 0);
      chk("reset tick_out", int'(tick_out), 0);
      chk("reset clk_out", int'(clk_out), 0);
      chk("reset ack/err", int'({div_ack, div_err}), 0);
      rst_n = 1'b1;

      // Default divisors: ticks at edges 13, 25, 37.
      idle(40, '0);
      chk("tick0 count after 40 edges", t0_hits.size(), 3);
      chk("first tick0 edge", (t0_hits.size() > 0) ? t0_hits[0] : -1, 13);
      chk("second tick0 edge", (t0_hits.size() > 1) ? t0_hits[1] : -1, 25);
      chk("clk_out0 high before clr", int'(clk_out[0]), 1);

      // clr at edge 41: next tick0 13 edges later.
      drive(1'b1, 1'b1, 1'b0, 0, 0, '0);
      chk("clk_out after clr", int'(clk_out), 0);
      idle(20, '0);
      chk("tick0 after clr edge", (t0_hits.size() > 3) ? t0_hits[3] : -1, 54);

      drive(1'b1, 1'b0, 1'b1, 1, 1, '0);
      idle(20, '0);
      drive(1'b1, 1'b0, 1'b1, 0, 0, '0);
      idle(3, '0);
      drive(1'b1, 1'b0, 1'b1, 3, 5, '0);
      idle(10, '0);
      repeat (10) drive(1'b0, 1'b0, 1'b0, 0, 0, '0);
      idle(30, '0);

      drive(1'b1, 1'b0, 1'b1, 2, 8, '0);
      idle(40, 3'b100);
      idle(40, '0);

      f_r = '0;
      repeat (3000) begin
         if ($urandom_range(0, 19) == 0) f_r = NUM_CH'($urandom);
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), f_r);
      end
      idle(5, '0);
      chk("scoreboard drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
